alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset: clk (rising edge) and rst; rst asserts immediately and deasserts synchronously to clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request; sampled only when busy=0.
REQ-005 alu_control  input  4  operation code, captured with start.
REQ-006 a, b  input  32 each  operands, captured with start.
REQ-007 shamt  input  5  shift amount, captured with start.
REQ-008 busy  output  1  multiply iteration in progress.
REQ-009 done  output  1  one-cycle pulse; result and flags valid.
REQ-010 result  output  32  operation result, held until the next done.
REQ-011 zero  output  1  result==0, updated with done.
REQ-012 overflow  output  1  signed overflow for ADD/SUB, else 0.
REQ-013 hi, lo  output  32 each  multiply accumulator registers.

Function
REQ-014 Codes SHALL be 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1000 MADD, 1001 MADDU, 1010 MUL, 1100 NOT (~a), 1101 XOR, 1110 SLL (b<<shamt), 1111 SRL (logical b>>shamt).
REQ-015 Start SHALL be accepted on a rising edge with start=1 and busy=0, including the cycle in which done=1; start while busy=1 SHALL be ignored.
REQ-016 FSM states SHALL be IDLE and MULT; operation codes other than 1000/1001/1010 SHALL complete from IDLE, and 1000/1001/1010 SHALL enter MULT.
REQ-017 A single-cycle operation SHALL assert done, result, zero and overflow in the cycle after acceptance (latency 1); busy SHALL stay 0.
REQ-018 ADD/SUB SHALL wrap modulo 2^32; overflow=1 iff the operands' signs cause a signed overflow (ADD: same-sign operands with a differently signed result; SUB: differently signed operands with result sign != a).
REQ-019 MULT SHALL run a shift-add iteration over 32 cycles using a 6-bit counter (0..31), with busy=1 from the cycle after acceptance through the last iteration.
REQ-020 Signed products (MADD, MUL) SHALL multiply operand magnitudes and negate the 64-bit product when the operand signs differ; MADDU SHALL use unsigned operands.
REQ-021 done SHALL pulse in the cycle after the final iteration: 33 cycles after acceptance; busy SHALL fall in that same cycle.
REQ-022 MADD/MADDU SHALL set {hi,lo} = {hi,lo} + product (mod 2^64), and result SHALL equal the new lo.
REQ-023 MUL SHALL set result = low 32 bits of the signed product and leave hi/lo unchanged.
REQ-024 Undefined codes (0011,0100,0101,0111,1011) SHALL complete as single-cycle operations with result=0, zero=1, overflow=0.
REQ-025 Operands and opcode SHALL be registered at acceptance; input changes during MULT SHALL not affect the result.
REQ-026 overflow SHALL be 0 for all non-ADD/SUB operations; done SHALL never remain high for two consecutive cycles unless a new single-cycle operation is accepted in the cycle done is high.

Reset
REQ-027 On rst: state=IDLE, busy=0, done=0, result=0, zero=0, overflow=0, hi=0, lo=0, counter=0.
REQ-028 rst during MULT SHALL abort the operation; no done pulse SHALL follow and hi/lo SHALL read 0.

Verification
REQ-029 ADD a=0x7FFFFFFF, b=1 -> next cycle done=1, result=0x80000000, overflow=1, zero=0.
REQ-030 SUB a=5, b=5 -> next cycle result=0, zero=1, overflow=0; SRL b=0x80000000, shamt=31 -> result=1.
REQ-031 MUL a=-3 (0xFFFFFFFD), b=7 -> busy for 32 cycles, done 33 cycles after start, result=0xFFFFFFEB, hi/lo unchanged.
REQ-032 From reset, MADDU a=0xFFFFFFFF, b=2 then MADD a=-1, b=1 -> first gives hi=1, lo=0xFFFFFFFE; second gives hi=1, lo=0xFFFFFFFD.
REQ-033 Start pulsed at cycle 10 of a MULT -> ignored; only one done pulse occurs, at cycle 33 after the original acceptance.
REQ-034 rst asserted at cycle 15 of MADD -> busy=0 immediately, hi=lo=0, no done; a following ADD 2+3 -> result=5.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-cycle ALU plus a 32-cycle shift-add multiplier with hi/lo accumulation
module alu_exec_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  alu_control,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic {IDLE, MULT} state_t;
  state_t state, state_n;
  logic [3:0]  op;
  logic [63:0] mcand, prod, pacc, pfin, hl;
  logic [31:0] mplier, alu_r, sum, dif, ma, mb, mres;
  logic [5:0]  cnt;
  logic        neg, accept, is_mul, sgn, last, alu_v;
  assign busy   = state == MULT;
  assign accept = start && state == IDLE;
  assign is_mul = alu_control[3] && !alu_control[2] && alu_control[1:0] != 2'b11;
  assign last   = state == MULT && cnt == 6'd31;
  assign sum    = a + b;
  assign dif    = a - b;
  assign sgn    = alu_control != 4'b1001;
  assign ma     = sgn && a[31] ? -a : a;
  assign mb     = sgn && b[31] ? -b : b;
  assign pacc   = prod + (mplier[0] ? mcand : 64'd0);
  assign pfin   = neg ? -pacc : pacc;
  assign hl     = {hi, lo} + pfin;
  assign mres   = op == 4'b1010 ? pfin[31:0] : hl[31:0];
  always_comb begin
    alu_r = 32'd0;
    alu_v = 1'b0;
    case (alu_control)
      4'b0000: alu_r = a & b;
      4'b0001: alu_r = a | b;
      4'b0010: begin
        alu_r = sum;
        alu_v = a[31] == b[31] && sum[31] != a[31];
      end
      4'b0110: begin
        alu_r = dif;
        alu_v = a[31] != b[31] && dif[31] != a[31];
      end
      4'b1100: alu_r = ~a;
      4'b1101: alu_r = a ^ b;
      4'b1110: alu_r = b << shamt;
      4'b1111: alu_r = b >> shamt;
      default: alu_r = 32'd0;
    endcase
  end
  always_comb state_n = state == IDLE ? (accept && is_mul ? MULT : IDLE) : (last ? IDLE : MULT);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op       <= 4'd0;
      mcand    <= 64'd0;
      mplier   <= 32'd0;
      prod     <= 64'd0;
      neg      <= 1'b0;
      cnt      <= 6'd0;
      done     <= 1'b0;
      result   <= 32'd0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else begin
      done <= 1'b0;
      if (accept && is_mul) begin
        op     <= alu_control;
        mcand  <= {32'd0, ma};
        mplier <= mb;
        prod   <= 64'd0;
        neg    <= sgn && (a[31] ^ b[31]);
        cnt    <= 6'd0;
      end else if (accept) begin
        done     <= 1'b1;
        result   <= alu_r;
        zero     <= alu_r == 32'd0;
        overflow <= alu_v;
      end else if (state == MULT) begin
        prod   <= pacc;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= last ? 6'd0 : cnt + 6'd1;
        if (last) begin
          done     <= 1'b1;
          result   <= mres;
          zero     <= mres == 32'd0;
          overflow <= 1'b0;
          if (op != 4'b1010) {hi, lo} <= hl;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: randomized self-checking bench against an arithmetic reference model
module tb_alu_exec_unit;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [3:0] alu_control = 4'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic [4:0] shamt = 5'd0;
  logic busy, done, zero, overflow;
  logic [31:0] result, hi, lo;
  int checks = 0, passes = 0;
  logic [63:0] mhl = 64'd0;

  alu_exec_unit dut (.clk(clk), .rst(rst), .start(start), .alu_control(alu_control), .a(a), .b(b),
    .shamt(shamt), .busy(busy), .done(done), .result(result), .zero(zero), .overflow(overflow),
    .hi(hi), .lo(lo));

  always #5 clk = ~clk;

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic void model1(input logic [3:0] op, input logic [31:0] x, y, input logic [4:0] s,
                                 output logic [31:0] r, output logic v);
    longint t;
    r = 32'd0;
    v = 1'b0;
    case (op)
      4'd0: r = x & y;
      4'd1: r = x | y;
      4'd2: begin t = longint'($signed(x)) + longint'($signed(y)); r = t[31:0]; v = t != longint'($signed(r)); end
      4'd6: begin t = longint'($signed(x)) - longint'($signed(y)); r = t[31:0]; v = t != longint'($signed(r)); end
      4'd12: r = ~x;
      4'd13: r = x ^ y;
      4'd14: r = y << s;
      4'd15: r = y >> s;
      default: r = 32'd0;
    endcase
  endfunction

  function automatic logic [63:0] product(input logic [3:0] op, input logic [31:0] x, y);
    if (op == 4'd9) return {32'd0, x} * {32'd0, y};
    return longint'($signed(x)) * longint'($signed(y));
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] x, y, input logic [4:0] s);
    @(negedge clk);
    start = 1'b1; alu_control = op; a = x; b = y; shamt = s;
    @(posedge clk);
    #1 start = 1'b0; a = $urandom; b = $urandom; shamt = 5'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mhl = 64'd0;
  endtask

  task automatic run_mul(input logic [3:0] op, input logic [31:0] x, y, input int inj,
                         output int lat, output int bc);
    lat = 0; bc = 0;
    drive(op, x, y, 5'd0);
    for (int c = 1; c <= 40; c++) begin
      if (busy) bc++;
      if (done) begin lat = c; break; end
      start = c == inj;
      alu_control = 4'd2; a = $urandom; b = $urandom;
      @(posedge clk);
      #1 start = 1'b0;
    end
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, zero, overflow, result, hi, lo} !== 100'd0)
      $display("FAIL reset_state got %h want 0", {busy, done, zero, overflow, result, hi, lo});
    else passes++;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [3:0] ops[3] = '{4'd2, 4'd6, 4'd15};
    logic [31:0] xs[3] = '{32'h7FFFFFFF, 32'd5, 32'd0};
    logic [31:0] ys[3] = '{32'd1, 32'd5, 32'h80000000};
    logic [31:0] rs[3] = '{32'h80000000, 32'd0, 32'd1};
    logic [2:0] fl[3] = '{3'b101, 3'b010, 3'b100};
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], xs[i], ys[i], 5'd31);
      checks++;
      if ({done, busy, result, zero, overflow} !== {1'b1, 1'b0, rs[i], fl[i][1:0]})
        $display("FAIL directed_%0d got done=%b busy=%b r=%h z=%b v=%b want r=%h zv=%b",
                 i, done, busy, result, zero, overflow, rs[i], fl[i][1:0]);
      else passes++;
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) $display("FAIL directed_done_drop_%0d got %b want 0", i, done);
      else passes++;
    end
  endtask

  task automatic test_random_single();
    logic [3:0] op; logic [31:0] x, y, er; logic [4:0] s; logic ev;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op inside {4'd8, 4'd9, 4'd10}) op = 4'd2;
      x = rnd(); y = rnd(); s = 5'($urandom);
      model1(op, x, y, s, er, ev);
      drive(op, x, y, s);
      checks++;
      if ({done, busy, result, zero, overflow} !== {2'b10, er, er == 32'd0, ev})
        $display("FAIL single op=%h a=%h b=%h s=%0d got r=%h z=%b v=%b d=%b want r=%h z=%b v=%b",
                 op, x, y, s, result, zero, overflow, done, er, er == 32'd0, ev);
      else passes++;
    end
  endtask

  task automatic check_mul(input string nm, input logic [3:0] op, input logic [31:0] x, y, input int inj);
    int lat, bc; logic [63:0] p; logic [31:0] er;
    p = product(op, x, y);
    if (op != 4'd10) mhl = mhl + p;
    er = op == 4'd10 ? p[31:0] : mhl[31:0];
    run_mul(op, x, y, inj, lat, bc);
    checks++;
    if (lat != 33 || bc != 32) $display("FAIL %s_timing got lat=%0d busy=%0d want 33/32", nm, lat, bc);
    else passes++;
    checks++;
    if ({result, zero, overflow, hi, lo} !== {er, er == 32'd0, 1'b0, mhl})
      $display("FAIL %s_value got r=%h z=%b v=%b hi=%h lo=%h want r=%h hilo=%h",
               nm, result, zero, overflow, hi, lo, er, mhl);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if ({done, busy} !== 2'b00) $display("FAIL %s_single_done got done=%b busy=%b want 00", nm, done, busy);
    else passes++;
  endtask

  task automatic test_mul();
    check_mul("mul_neg3x7", 4'd10, 32'hFFFFFFFD, 32'd7, 0);
    for (int i = 0; i < 6; i++)
      check_mul("mul_rand", 4'($urandom_range(8, 10)), rnd(), rnd(), 0);
  endtask

  task automatic test_madd();
    do_reset();
    check_mul("maddu", 4'd9, 32'hFFFFFFFF, 32'd2, 0);
    checks++;
    if ({hi, lo} !== 64'h1_FFFFFFFE) $display("FAIL maddu_hilo got %h%h want 00000001fffffffe", hi, lo);
    else passes++;
    check_mul("madd", 4'd8, 32'hFFFFFFFF, 32'd1, 0);
    checks++;
    if ({hi, lo} !== 64'h1_FFFFFFFD) $display("FAIL madd_hilo got %h%h want 00000001fffffffd", hi, lo);
    else passes++;
  endtask

  task automatic test_start_ignored();
    check_mul("busy_start", 4'd10, 32'd123456, 32'hFFFFFF00, 10);
  endtask

  task automatic test_back_to_back();
    logic [3:0] op; logic [31:0] x, y, er; logic ev; int lat, bc;
    run_mul(4'd10, 32'd9, 32'd9, 0, lat, bc);
    checks++;
    if (lat != 33 || result !== 32'd81) $display("FAIL b2b_mul got lat=%0d r=%h want 33/51", lat, result);
    else passes++;
    for (int i = 0; i < 8; i++) begin
      op = i[0] ? 4'd6 : 4'd13;
      x = rnd(); y = rnd();
      model1(op, x, y, 5'd0, er, ev);
      start = 1'b1; alu_control = op; a = x; b = y; shamt = 5'd0;
      @(posedge clk); #1;
      checks++;
      if ({done, result, overflow} !== {1'b1, er, ev})
        $display("FAIL b2b_%0d got d=%b r=%h v=%b want 1 %h %b", i, done, result, overflow, er, ev);
      else passes++;
    end
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) $display("FAIL b2b_end got done=%b want 0", done);
    else passes++;
  endtask

  task automatic test_abort();
    int nd = 0;
    drive(4'd8, 32'd77, 32'd1000, 5'd0);
    repeat (14) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    mhl = 64'd0;
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) $display("FAIL abort_state got busy=%b done=%b hi=%h lo=%h want 0", busy, done, hi, lo);
    else passes++;
    @(negedge clk) rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    checks++;
    if (nd != 0) $display("FAIL abort_no_done got %0d pulses want 0", nd);
    else passes++;
    drive(4'd2, 32'd2, 32'd3, 5'd0);
    checks++;
    if ({done, result, zero, overflow, hi, lo} !== {1'b1, 32'd5, 2'b00, 64'd0})
      $display("FAIL abort_add got d=%b r=%h hi=%h lo=%h want 1 5 0 0", done, result, hi, lo);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_single();
    test_mul();
    test_madd();
    test_start_ignored();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
